// File: rtl/team_06_pwm_dac.sv
// 8-bit PWM audio DAC with a 255-cycle period, double-buffered duty sample,
// graceful stop at end of period and a sticky underrun flag.
module team_06_pwm_dac #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic       clkdiv,
    input  logic       nrst,
    input  logic [7:0] audio_in,
    input  logic       sample_valid,
    input  logic       en,
    input  logic       clr_underrun,
    output logic       pwm_out,
    output logic       sample_req,
    output logic       underrun
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'd254;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic [7:0] cnt_nxt;
    logic [7:0] duty;
    logic [7:0] duty_nxt;
    logic [7:0] shadow;
    logic       shadow_full;
    logic       shadow_full_nxt;
    logic       period_start;
    logic       underrun_set;

    // Next-state and period-start decode; a period that ends with en=0
    // returns to IDLE instead of starting a new period.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        period_start = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    state_nxt    = RUN;
                    period_start = 1'b1;
                end
            end
            RUN, STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_nxt = '0;
                    if (en) begin
                        state_nxt    = RUN;
                        period_start = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt   = cnt + 8'd1;
                    state_nxt = en ? RUN : STOP;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Duty hand-over: the shadow is consumed before any same-edge sample
    // refills it, so a coincident sample waits for the following period.
    always_comb begin
        duty_nxt        = duty;
        shadow_full_nxt = shadow_full;
        underrun_set    = 1'b0;
        if (period_start) begin
            if (shadow_full) begin
                duty_nxt        = shadow;
                shadow_full_nxt = 1'b0;
            end else if (state == IDLE) begin
                duty_nxt = '0;
            end else begin
                underrun_set = 1'b1;
            end
        end
        if (sample_valid) begin
            shadow_full_nxt = 1'b1;
        end
    end

    // pwm_out is computed from next-cycle cnt/duty so the register matches
    // (cnt < duty) in the cycle it is visible.
    always_ff @(posedge clkdiv or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            duty        <= '0;
            shadow      <= '0;
            shadow_full <= 1'b0;
            pwm_out     <= IDLE_LEVEL;
            sample_req  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            duty        <= duty_nxt;
            shadow_full <= shadow_full_nxt;
            if (sample_valid) begin
                shadow <= audio_in;
            end
            sample_req <= period_start;
            pwm_out    <= (state_nxt == IDLE) ? IDLE_LEVEL : (cnt_nxt < duty_nxt);
            underrun   <= underrun_set | (underrun & ~clr_underrun);
        end
    end

endmodule

// File: doc/team_06_pwm_dac.md
TEAM_06_PWM_DAC -- requirements
Module: team_06_pwm_dac

Interface
REQ-001 SHALL have parameter IDLE_LEVEL, default 1'b0, pwm_out level while stopped or in reset.
REQ-002 SHALL have port clkdiv input 1: system clock, all state on rising edge.
REQ-003 SHALL have port nrst input 1: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port audio_in input 8: unsigned sample from the effect chain (tremolo output).
REQ-005 SHALL have port sample_valid input 1: one-cycle strobe, audio_in is valid this cycle.
REQ-006 SHALL have port en input 1: level, 1 = run PWM, 0 = stop at end of current period.
REQ-007 SHALL have port clr_underrun input 1: one-cycle strobe, clears underrun.
REQ-008 SHALL have port pwm_out output 1: registered PWM audio output.
REQ-009 SHALL have port sample_req output 1: one-cycle pulse at each period start, requesting the next sample.
REQ-010 SHALL have port underrun output 1: sticky flag, a period started with no fresh sample.

Function
REQ-011 SHALL hold an 8-bit period counter cnt counting 0..254 and wrapping to 0, period = 255 cycles.
REQ-012 SHALL double-buffer samples: shadow register plus shadow_full flag; active register duty.
REQ-013 SHALL, on sample_valid in any state, load shadow<=audio_in and set shadow_full.
REQ-014 SHALL overwrite shadow on repeated sample_valid before consumption, last wins, no error.
REQ-015 SHALL implement states IDLE, RUN, STOP.
REQ-016 IDLE: cnt held at 0, pwm_out=IDLE_LEVEL, sample_req=0; en=1 -> RUN on next edge (period start).
REQ-017 RUN: cnt increments each cycle; en=0 -> STOP, cnt keeps counting.
REQ-018 STOP: current period completes; en=1 -> RUN with no period interruption; at cnt==254 with en=0 -> IDLE, cnt<=0.
REQ-019 Period start = the edge at which cnt becomes 0 while entering or remaining in RUN; no period start on the STOP->IDLE transition.
REQ-020 At period start: if shadow_full then duty<=shadow and shadow_full<=0; else duty unchanged.
REQ-021 At period start from RUN/STOP with shadow_full=0, underrun<=1.
REQ-022 First period after IDLE with shadow_full=0: duty<=0, underrun not set.
REQ-023 sample_valid on the period-start edge: duty takes the old shadow, shadow takes audio_in, shadow_full stays 1; if shadow was empty, duty follows REQ-020/022 and the new sample waits.
REQ-024 sample_req SHALL be 1 exactly in the first cycle of each period (cnt==0 in RUN/STOP), else 0.
REQ-025 pwm_out SHALL be a register equal, in each cycle, to (cnt < duty) for that cycle while in RUN/STOP: high for exactly duty cycles per period, starting at cnt=0; duty=255 is 100%, duty=0 is 0%.
REQ-026 underrun SHALL be cleared by clr_underrun; simultaneous set and clear -> set wins.
REQ-027 All compares unsigned 8-bit; no arithmetic on audio_in.

Reset
REQ-028 nrst=0 SHALL immediately, without a clock, force state=IDLE, cnt=0, duty=0, shadow=0, shadow_full=0, pwm_out=IDLE_LEVEL, sample_req=0, underrun=0.
REQ-029 Deassertion SHALL be synchronized by the integrator; the block SHALL leave IDLE no earlier than the first edge after release with en=1.

Verification
REQ-030 Reset mid-run at cnt=100, duty=0xE5 -> pwm_out, sample_req, underrun all 0 same timestep; after release with en=1, first period duty=0.
REQ-031 sample_valid with 0xE5 each period, en=1 -> every 255-cycle period has pwm_out high 229 cycles then low 26; sample_req one pulse per 255 cycles; underrun stays 0.
REQ-032 Samples 0xFF then 0x04 -> one period high all 255 cycles, next period high exactly 4 cycles.
REQ-033 Omit sample_valid for one period -> duty repeats the previous value, underrun=1 from that period start; clr_underrun -> 0 next cycle; clear coincident with new underrun -> stays 1.
REQ-034 en=0 at cnt=100 -> pwm_out waveform continues unchanged to cnt=254, then IDLE_LEVEL, no further sample_req; en=1 during STOP -> next period starts on schedule.
REQ-035 sample_valid 0x10 on the period-start edge with shadow holding 0x80 -> that period high 128 cycles, next period high 16 cycles, no underrun.
